// File: rtl/button_input_debouncer.sv
// Multi-channel pushbutton conditioner: two-flop synchroniser, per-channel stability
// counter, press/release pulses and a combined press counter, all registered.
module button_input_debouncer #(
    parameter int WIDTH          = 4,
    parameter int DEBOUNCE_COUNT = 120000,
    parameter int CNT_WIDTH      = 17,
    parameter bit ACTIVE_LOW     = 1'b1,
    parameter int EVENT_WIDTH    = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [WIDTH-1:0]       BUTTON,
    output logic [WIDTH-1:0]       STATE,
    output logic [WIDTH-1:0]       PRESS,
    output logic [WIDTH-1:0]       RELEASE,
    output logic [EVENT_WIDTH-1:0] PRESS_COUNT
);

    localparam logic [WIDTH-1:0]     IDLE_LVL = {WIDTH{ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    function automatic logic [EVENT_WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [EVENT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + EVENT_WIDTH'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0]       s1_q;
    logic [WIDTH-1:0]       s2_q;
    logic [WIDTH-1:0]       norm_s;
    logic [CNT_WIDTH-1:0]   cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0]   cnt_d [WIDTH];
    logic [WIDTH-1:0]       state_q;
    logic [WIDTH-1:0]       state_d;
    logic [WIDTH-1:0]       press_q;
    logic [WIDTH-1:0]       press_d;
    logic [WIDTH-1:0]       release_q;
    logic [WIDTH-1:0]       release_d;
    logic [EVENT_WIDTH-1:0] press_count_q;
    logic [EVENT_WIDTH-1:0] press_count_d;

    // Synchroniser stages rest at the not-pressed pin level so reset never looks like a press.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q <= IDLE_LVL;
            s2_q <= IDLE_LVL;
        end else begin
            s1_q <= BUTTON;
            s2_q <= s1_q;
        end
    end

    // Per-channel stability counting; a level is accepted only after an unbroken run.
    always_comb begin
        norm_s    = s2_q ^ IDLE_LVL;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            cnt_d[ch] = '0;
            if (norm_s[ch] == state_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                state_d[ch]   = norm_s[ch];
                press_d[ch]   = norm_s[ch];
                release_d[ch] = ~norm_s[ch];
                cnt_d[ch]     = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_WIDTH'(1);
            end
        end
        press_count_d = press_count_q + popcount(press_d);
    end

    // Debounce state, pulses and the wrapping press tally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                cnt_q[ch] <= '0;
            end
            state_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            press_count_q <= '0;
        end else begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            state_q       <= state_d;
            press_q       <= press_d;
            release_q     <= release_d;
            press_count_q <= press_count_d;
        end
    end

    assign STATE       = state_q;
    assign PRESS       = press_q;
    assign RELEASE     = release_q;
    assign PRESS_COUNT = press_count_q;

endmodule

// File: tb/tb_button_input_debouncer.sv
// Scoreboard bench: a sliding-window reference model predicts every cycle's outputs for
// two debouncer configurations; a negedge monitor pops and compares.
module tb_button_input_debouncer;

    localparam int   DC_A = 4;
    localparam logic AL_A = 1'b1;
    localparam int   DC_B = 1;
    localparam logic AL_B = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_a, btn_b;
    logic [3:0] st_a, pr_a, rl_a, st_b, pr_b, rl_b;
    logic [7:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    button_input_debouncer #(.WIDTH(4), .DEBOUNCE_COUNT(DC_A), .CNT_WIDTH(3),
                             .ACTIVE_LOW(AL_A), .EVENT_WIDTH(8)) dut_a (
        .CLK(clk), .RESET(rst), .BUTTON(btn_a), .STATE(st_a), .PRESS(pr_a),
        .RELEASE(rl_a), .PRESS_COUNT(cnt_a));

    button_input_debouncer #(.WIDTH(4), .DEBOUNCE_COUNT(DC_B), .CNT_WIDTH(2),
                             .ACTIVE_LOW(AL_B), .EVENT_WIDTH(8)) dut_b (
        .CLK(clk), .RESET(rst), .BUTTON(btn_b), .STATE(st_b), .PRESS(pr_b),
        .RELEASE(rl_b), .PRESS_COUNT(cnt_b));

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [7:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    // hist[i][0] is the pin sample (pressed = 1) taken at the current edge, hist[i][k] k edges ago
    logic [3:0] hist [2][8];
    logic [3:0] m_state [2];
    logic [7:0] m_count [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // A level is accepted once the last dc samples seen past the synchroniser all agree and differ from the state.
    task automatic model_step(input int i, input logic [3:0] btn, input int dc, input logic al);
        exp_t       e;
        logic [3:0] old;
        bit         stable;
        e = '0;
        if (rst) begin
            for (int j = 0; j < 8; j++) hist[i][j] = 4'h0;
            m_state[i] = 4'h0;
            m_count[i] = 8'h00;
        end else begin
            for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = btn ^ {4{al}};
            old = m_state[i];
            for (int ch = 0; ch < 4; ch++) begin
                stable = 1'b1;
                for (int w = 3; w <= dc + 1; w++) begin
                    if (hist[i][w][ch] != hist[i][2][ch]) stable = 1'b0;
                end
                if (stable && hist[i][2][ch] != old[ch]) m_state[i][ch] = hist[i][2][ch];
            end
            e.pr = m_state[i] & ~old;
            e.rl = ~m_state[i] & old;
            m_count[i] = m_count[i] + 8'($countones(e.pr));
            e.st  = m_state[i];
            e.cnt = m_count[i];
        end
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    always @(posedge clk) begin
        model_step(0, btn_a, DC_A, AL_A);
        model_step(1, btn_b, DC_B, AL_B);
    end

    always @(negedge clk) begin
        while (q0.size() > 0) begin
            mon_e = q0.pop_front();
            check("a_state",   {28'h0, st_a}, {28'h0, mon_e.st});
            check("a_press",   {28'h0, pr_a}, {28'h0, mon_e.pr});
            check("a_release", {28'h0, rl_a}, {28'h0, mon_e.rl});
            check("a_count",   {24'h0, cnt_a}, {24'h0, mon_e.cnt});
        end
        while (q1.size() > 0) begin
            mon_e = q1.pop_front();
            check("b_state",   {28'h0, st_b}, {28'h0, mon_e.st});
            check("b_press",   {28'h0, pr_b}, {28'h0, mon_e.pr});
            check("b_release", {28'h0, rl_b}, {28'h0, mon_e.rl});
            check("b_count",   {24'h0, cnt_b}, {24'h0, mon_e.cnt});
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_state", {28'h0, st_a}, 32'h0);
        check("rst_async_press", {28'h0, pr_a}, 32'h0);
        check("rst_async_count", {24'h0, cnt_a}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        btn_a = 4'hF;
        btn_b = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_state", {28'h0, st_a, st_b} , 32'h0);
        check("reset_count", {16'h0, cnt_a, cnt_b}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single press and release on channel 0
        btn_a[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("t1_not_yet", {31'h0, st_a[0]}, 32'h0);
        @(posedge clk);
        #1 check("t1_state", {28'h0, st_a}, 32'h1);
        check("t1_press", {28'h0, pr_a}, 32'h1);
        check("t1_count", {24'h0, cnt_a}, 32'h1);
        @(posedge clk);
        #1 check("t1_press_one_cycle", {28'h0, pr_a}, 32'h0);
        @(negedge clk);
        btn_a[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("t1_release", {28'h0, rl_a}, 32'h1);
        check("t1_count_held", {24'h0, cnt_a}, 32'h1);
        repeat (3) @(negedge clk);

        // 2: bounce shorter than the debounce window on channel 1
        btn_a[1] = 1'b0; repeat (3) @(negedge clk);
        btn_a[1] = 1'b1; repeat (1) @(negedge clk);
        btn_a[1] = 1'b0; repeat (3) @(negedge clk);
        btn_a[1] = 1'b1; repeat (10) @(negedge clk);
        check("t2_state", {31'h0, st_a[1]}, 32'h0);
        check("t2_count", {24'h0, cnt_a}, 32'h1);

        // 3: all channels pressed together
        btn_a = 4'h0;
        repeat (6) @(posedge clk);
        #1 check("t3_press_all", {28'h0, pr_a}, 32'hF);
        check("t3_count", {24'h0, cnt_a}, 32'h5);
        @(negedge clk);
        btn_a = 4'hF;
        repeat (8) @(negedge clk);

        // 5: reset in the middle of a count, button held through reset
        btn_a[2] = 1'b0;
        repeat (4) @(posedge clk);
        pulse_reset();
        repeat (5) @(posedge clk);
        #1 check("t5_no_early_press", {28'h0, pr_a}, 32'h0);
        @(posedge clk);
        #1 check("t5_press", {28'h0, pr_a}, 32'h4);
        check("t5_count", {24'h0, cnt_a}, 32'h1);
        @(negedge clk);
        btn_a = 4'hF;
        repeat (8) @(negedge clk);

        // 4: preload 254 presses, then two more wrap to zero
        pulse_reset();
        for (int r = 0; r < 64; r++) begin
            btn_a = (r == 63) ? 4'b1100 : 4'b0000;
            repeat (7) @(negedge clk);
            btn_a = 4'hF;
            repeat (7) @(negedge clk);
        end
        check("t4_preload", {24'h0, cnt_a}, 32'd254);
        btn_a = 4'b1100;
        repeat (7) @(negedge clk);
        check("t4_wrap", {24'h0, cnt_a}, 32'h0);
        btn_a = 4'hF;
        repeat (7) @(negedge clk);

        // 6: active-high pins with a one-cycle debounce window
        btn_b[0] = 1'b1;
        @(posedge clk);
        #1 check("t6_edge_k", {28'h0, st_b}, 32'h0);
        @(posedge clk);
        #1 check("t6_edge_k1", {28'h0, st_b}, 32'h0);
        @(posedge clk);
        #1 check("t6_state", {28'h0, st_b}, 32'h1);
        check("t6_press", {28'h0, pr_b}, 32'h1);
        @(posedge clk);
        #1 check("t6_press_one_cycle", {28'h0, pr_b}, 32'h0);
        @(negedge clk);
        btn_b = 4'h0;
        repeat (4) @(negedge clk);

        // random bouncing on both configurations
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 3) == 0) btn_a[ch] = ~btn_a[ch];
                if ($urandom_range(0, 2) == 0) btn_b[ch] = ~btn_b[ch];
            end
            if (c == 1500) pulse_reset();
            else @(negedge clk);
        end
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
